parameter_controller: RTL and testbench
=======================================

PARAMETER_CONTROLLER -- requirements
Module: parameter_controller

Interface
REQ-001 Parameters SHALL be, one per line:
- CC_VOLUME, 7, MIDI CC number mapped to volume
- CC_UNISON_DETUNE, 94, CC mapped to unison_detune
- CC_ATTACK_TIME, 73, CC mapped to attack_time
- CC_DECAY_TIME, 75, CC mapped to decay_time
- CC_SUSTAIN_LEVEL, 79, CC mapped to sustain_level
- CC_RELEASE_TIME, 72, CC mapped to release_time
- CC_DUTY_CYCLE, 70, CC mapped to duty_cycle
- CC_RESET_ALL, 121, CC that restores defaults
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cc_valid  in  1  control-change event present this cycle (always accepted)
- cc_number  in  7  controller number
- cc_value  in  7  controller value
- pc_valid  in  1  program-change event present this cycle (always accepted)
- pc_program  in  7  program number
- parameters  out  parameter_t (49)  current parameter set
- wave  out  wave_t (3)  current wavetable select
- wave_changed  out  1  one-cycle pulse after wave update
- change_valid  out  1  change notification offered
- change_param  out  parameter_change_t (4)  parameter whose value changed
- change_ready  in  1  downstream accepts notification
REQ-003 Clock is clk, reset is rst_n; one clock domain; reset is asynchronous assert, active-low, fixed.

Function
REQ-004 cc_valid with cc_number equal to a mapped CC SHALL write cc_value into that field of parameters at the same edge and set that field's dirty bit.
REQ-005 cc_valid with an unmapped cc_number (not a mapped CC, not CC_RESET_ALL) SHALL be ignored: no register or dirty change.
REQ-006 cc_valid with cc_number == CC_RESET_ALL SHALL load DEFAULT_PARAMETERS and set all seven dirty bits at that edge, regardless of cc_value.
REQ-007 If two mapping parameters hold equal CC numbers, the lowest parameter_change_t index SHALL win; only that field updates.
REQ-008 pc_valid SHALL load wave <= pc_program[2:0] and assert wave_changed for exactly the following cycle; wave_changed SHALL pulse even if the value is unchanged.
REQ-009 Notification FSM SHALL have states IDLE and OFFER; IDLE: change_valid=0, change_param=PARAM_NONE.
REQ-010 IDLE with any dirty bit set SHALL, at the next edge, enter OFFER with change_param = lowest-index dirty parameter (PARAM_VOLUME highest priority).
REQ-011 In OFFER, change_valid=1; change_param SHALL stay stable until change_valid && change_ready.
REQ-012 On handshake edge, the offered dirty bit SHALL clear and FSM returns to IDLE; maximum rate one notification per two cycles.
REQ-013 A CC write to the offered parameter on the handshake edge SHALL leave its dirty bit set (set wins over clear); it is re-offered.
REQ-014 Repeated writes to an already-dirty parameter SHALL coalesce into one notification; parameters holds the last value written.
REQ-015 A CC write in the same cycle as pc_valid SHALL perform both independently.
REQ-016 Latency: CC accepted at edge N -> parameters updated after edge N -> change_valid earliest after edge N+1.
REQ-017 CC_RESET_ALL during OFFER SHALL NOT alter change_param; remaining parameters are offered afterward in priority order.

Reset
REQ-018 rst_n low SHALL asynchronously set parameters = DEFAULT_PARAMETERS (volume 0x40, detune 0, attack 0, decay 0, sustain 0x7F, release 0, duty 0x40), wave = SINE, wave_changed = 0, dirty = 0, FSM = IDLE, change_valid = 0, change_param = PARAM_NONE.
REQ-019 Reset asserted mid-OFFER SHALL drop the pending notification; no notifications follow deassertion until a new write.

Verification
REQ-020 CC 7 value 0x10, change_ready=1 -> volume=0x10 after edge N; change_valid/PARAM_VOLUME after edge N+1; single handshake; then IDLE.
REQ-021 CC 70 then CC 7 in consecutive cycles, change_ready=0 for 5 cycles -> PARAM_DUTY_CYCLE held stable 5 cycles; after ready, PARAM_VOLUME offered next.
REQ-022 CC 73 three times (0x01,0x02,0x03) while dirty -> attack_time=0x03, exactly one PARAM_ATTACK_TIME notification.
REQ-023 CC 121 after nonzero writes -> parameters = defaults; seven notifications in order VOLUME..DUTY_CYCLE.
REQ-024 CC 20 value 0x55 -> no change anywhere; program 0x0D -> wave=VIOLET? no: wave=3'd5 TRUMPET, wave_changed one cycle.
REQ-025 CC 72 written on the handshake edge of PARAM_RELEASE_TIME -> PARAM_RELEASE_TIME re-offered; rst_n pulse mid-OFFER -> outputs at reset values immediately.

Source files
------------

// File: rtl/parameter_controller_if.sv
// rtl/parameter_controller_if.sv - shared types and bus interface for parameter_controller
package parameter_controller_pkg;

  // Seven 7-bit synth parameters; volume occupies the most significant field.
  typedef struct packed {
    logic [6:0] volume;
    logic [6:0] unison_detune;
    logic [6:0] attack_time;
    logic [6:0] decay_time;
    logic [6:0] sustain_level;
    logic [6:0] release_time;
    logic [6:0] duty_cycle;
  } parameter_t;

  typedef enum logic [2:0] {
    SINE     = 3'd0,
    SQUARE   = 3'd1,
    SAW      = 3'd2,
    TRIANGLE = 3'd3,
    NOISE    = 3'd4,
    TRUMPET  = 3'd5,
    ORGAN    = 3'd6,
    VIOLIN   = 3'd7
  } wave_t;

  // Index order doubles as notification priority (lowest index first).
  typedef enum logic [3:0] {
    PARAM_VOLUME         = 4'd0,
    PARAM_UNISON_DETUNE  = 4'd1,
    PARAM_ATTACK_TIME    = 4'd2,
    PARAM_DECAY_TIME     = 4'd3,
    PARAM_SUSTAIN_LEVEL  = 4'd4,
    PARAM_RELEASE_TIME   = 4'd5,
    PARAM_DUTY_CYCLE     = 4'd6,
    PARAM_NONE           = 4'd15
  } parameter_change_t;

  localparam parameter_t DEFAULT_PARAMETERS = '{
    volume:        7'h40,
    unison_detune: 7'h00,
    attack_time:   7'h00,
    decay_time:    7'h00,
    sustain_level: 7'h7F,
    release_time:  7'h00,
    duty_cycle:    7'h40
  };

endpackage

interface parameter_controller_if;
  import parameter_controller_pkg::*;

  logic              cc_valid;
  logic [6:0]        cc_number;
  logic [6:0]        cc_value;
  logic              pc_valid;
  logic [6:0]        pc_program;
  parameter_t        parameters;
  wave_t             wave;
  logic              wave_changed;
  logic              change_valid;
  parameter_change_t change_param;
  logic              change_ready;

  modport master (
    output cc_valid, cc_number, cc_value, pc_valid, pc_program, change_ready,
    input  parameters, wave, wave_changed, change_valid, change_param
  );

  modport slave (
    input  cc_valid, cc_number, cc_value, pc_valid, pc_program, change_ready,
    output parameters, wave, wave_changed, change_valid, change_param
  );

endinterface

// File: rtl/parameter_controller.sv
// rtl/parameter_controller.sv - MIDI CC/PC driven synth parameter store with change notifications
module parameter_controller
  import parameter_controller_pkg::*;
#(
  parameter logic [6:0] CC_VOLUME         = 7'd7,
  parameter logic [6:0] CC_UNISON_DETUNE  = 7'd94,
  parameter logic [6:0] CC_ATTACK_TIME    = 7'd73,
  parameter logic [6:0] CC_DECAY_TIME     = 7'd75,
  parameter logic [6:0] CC_SUSTAIN_LEVEL  = 7'd79,
  parameter logic [6:0] CC_RELEASE_TIME   = 7'd72,
  parameter logic [6:0] CC_DUTY_CYCLE     = 7'd70,
  parameter logic [6:0] CC_RESET_ALL      = 7'd121
) (
  input logic                  clk,
  input logic                  rst_n,
  parameter_controller_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  // Entry i holds the CC number for parameter_change_t index i.
  localparam logic [6:0] CC_MAP [7] = '{
    CC_VOLUME, CC_UNISON_DETUNE, CC_ATTACK_TIME, CC_DECAY_TIME,
    CC_SUSTAIN_LEVEL, CC_RELEASE_TIME, CC_DUTY_CYCLE
  };

  // Ascending packed range so field i lines up with parameter_change_t index i.
  logic [0:6][6:0]   regs_q, regs_d;
  logic [6:0]        dirty_q, dirty_d;
  wave_t             wave_q;
  logic              wave_changed_q;
  state_t            state_q;
  logic              change_valid_q;
  parameter_change_t change_param_q;
  parameter_change_t lowest_dirty;
  logic              handshake;
  logic              hit;
  logic              unused_pc;

  assign unused_pc = ^bus.pc_program[6:3];
  assign handshake = (state_q == OFFER) && bus.change_ready;

  // Highest-priority dirty parameter, PARAM_NONE when nothing is pending.
  always_comb begin
    lowest_dirty = PARAM_NONE;
    for (int i = 6; i >= 0; i--) begin
      if (dirty_q[i]) lowest_dirty = parameter_change_t'(4'(i));
    end
  end

  // Next parameter values and dirty bits; a CC set on the handshake edge overrides the clear.
  always_comb begin
    regs_d  = regs_q;
    dirty_d = dirty_q;
    hit     = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (handshake && (change_param_q == parameter_change_t'(4'(i)))) dirty_d[i] = 1'b0;
    end
    if (bus.cc_valid) begin
      if (bus.cc_number == CC_RESET_ALL) begin
        regs_d  = DEFAULT_PARAMETERS;
        dirty_d = 7'h7F;
      end else begin
        for (int i = 0; i < 7; i++) begin
          if (!hit && (bus.cc_number == CC_MAP[i])) begin
            hit       = 1'b1;
            regs_d[i] = bus.cc_value;
            dirty_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // Parameter and dirty-bit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= DEFAULT_PARAMETERS;
      dirty_q <= '0;
    end else begin
      regs_q  <= regs_d;
      dirty_q <= dirty_d;
    end
  end

  // Wavetable select with a one-cycle change pulse on every program change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_q         <= SINE;
      wave_changed_q <= 1'b0;
    end else begin
      wave_changed_q <= bus.pc_valid;
      if (bus.pc_valid) wave_q <= wave_t'(bus.pc_program[2:0]);
    end
  end

  // Notification FSM: offer the highest-priority dirty parameter, hold it until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      change_valid_q <= 1'b0;
      change_param_q <= PARAM_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (|dirty_q) begin
            state_q        <= OFFER;
            change_valid_q <= 1'b1;
            change_param_q <= lowest_dirty;
          end
        end
        OFFER: begin
          if (bus.change_ready) begin
            state_q        <= IDLE;
            change_valid_q <= 1'b0;
            change_param_q <= PARAM_NONE;
          end
        end
        default: begin
          state_q        <= IDLE;
          change_valid_q <= 1'b0;
          change_param_q <= PARAM_NONE;
        end
      endcase
    end
  end

  assign bus.parameters   = regs_q;
  assign bus.wave         = wave_q;
  assign bus.wave_changed = wave_changed_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_param = change_param_q;

endmodule

// File: tb/tb_parameter_controller.sv
// tb/tb_parameter_controller.sv - directed and random checks of parameter_controller against a reference model
module tb_parameter_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  parameter_controller_if bus ();

  parameter_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: field values, pending-change set, and the notification on offer.
  localparam logic [6:0] MAP  [7] = '{7'd7, 7'd94, 7'd73, 7'd75, 7'd79, 7'd72, 7'd70};
  localparam logic [6:0] DEFS [7] = '{7'h40, 7'h00, 7'h00, 7'h00, 7'h7F, 7'h00, 7'h40};
  logic [6:0] m_par [7];
  logic [6:0] m_dirty;
  logic       m_off;
  int         m_idx;
  logic [2:0] m_wave;
  logic       m_wchg;
  int         notes [7];

  function automatic int lowest(input logic [6:0] d);
    for (int i = 0; i < 7; i++) if (d[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) begin
      m_par[i] = DEFS[i];
      notes[i] = 0;
    end
    m_dirty = '0;
    m_off   = 1'b0;
    m_idx   = 15;
    m_wave  = 3'd0;
    m_wchg  = 1'b0;
  endtask

  task automatic model_edge(input logic cv, input logic [6:0] cn, input logic [6:0] cval,
                            input logic pv, input logic [6:0] pp, input logic rdy);
    logic [6:0] pre;
    pre = m_dirty;
    if (m_off && rdy) begin
      m_dirty[m_idx] = 1'b0;
      notes[m_idx]++;
      m_off = 1'b0;
      m_idx = 15;
    end else if (!m_off && pre != 0) begin
      m_off = 1'b1;
      m_idx = lowest(pre);
    end
    if (cv) begin
      if (cn == 7'd121) begin
        for (int i = 0; i < 7; i++) m_par[i] = DEFS[i];
        m_dirty = 7'h7F;
      end else begin
        for (int i = 0; i < 7; i++) begin
          if (cn == MAP[i]) begin
            m_par[i]   = cval;
            m_dirty[i] = 1'b1;
            break;
          end
        end
      end
    end
    m_wchg = pv;
    if (pv) m_wave = pp[2:0];
  endtask

  task automatic check_all(input string tag);
    logic [48:0] exp_par;
    exp_par = {m_par[0], m_par[1], m_par[2], m_par[3], m_par[4], m_par[5], m_par[6]};
    checks++;
    assert (bus.parameters === exp_par) else begin
      errors++;
      $error("FAIL %s.parameters: observed=%h expected=%h", tag, bus.parameters, exp_par);
    end
    checks++;
    assert (bus.wave === m_wave) else begin
      errors++;
      $error("FAIL %s.wave: observed=%0d expected=%0d", tag, bus.wave, m_wave);
    end
    checks++;
    assert (bus.wave_changed === m_wchg) else begin
      errors++;
      $error("FAIL %s.wave_changed: observed=%b expected=%b", tag, bus.wave_changed, m_wchg);
    end
    checks++;
    assert (bus.change_valid === m_off) else begin
      errors++;
      $error("FAIL %s.change_valid: observed=%b expected=%b", tag, bus.change_valid, m_off);
    end
    checks++;
    assert (bus.change_param === 4'(m_idx)) else begin
      errors++;
      $error("FAIL %s.change_param: observed=%0d expected=%0d", tag, bus.change_param, m_idx);
    end
  endtask

  task automatic step(input string tag, input logic cv, input logic [6:0] cn, input logic [6:0] cval,
                      input logic pv, input logic [6:0] pp, input logic rdy);
    bus.cc_valid     = cv;
    bus.cc_number    = cn;
    bus.cc_value     = cval;
    bus.pc_valid     = pv;
    bus.pc_program   = pp;
    bus.change_ready = rdy;
    @(posedge clk);
    model_edge(cv, cn, cval, pv, pp, rdy);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 7'd0, 7'd0, 1'b0, 7'd0, rdy);
  endtask

  task automatic check_count(input string tag, input int idx, input int expected);
    checks++;
    assert (notes[idx] === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, notes[idx], expected);
    end
  endtask

  logic       r_cv, r_pv, r_rdy;
  logic [6:0] r_cn, r_val, r_pp;
  int         r_sel;

  initial begin
    rst_n            = 1'b0;
    bus.cc_valid     = 1'b0;
    bus.cc_number    = '0;
    bus.cc_value     = '0;
    bus.pc_valid     = 1'b0;
    bus.pc_program   = '0;
    bus.change_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Single volume write, immediate acceptance.
    step("vol_write", 1'b1, 7'd7, 7'h10, 1'b0, 7'd0, 1'b1);
    idle("vol_notify", 3, 1'b1);
    check_count("vol_count", 0, 1);

    // Duty then volume; downstream stalls, duty offered first.
    step("duty_write", 1'b1, 7'd70, 7'h22, 1'b0, 7'd0, 1'b0);
    step("vol_write2", 1'b1, 7'd7, 7'h33, 1'b0, 7'd0, 1'b0);
    idle("stall", 5, 1'b0);
    idle("drain", 5, 1'b1);

    // Coalescing of repeated writes to one field.
    step("atk1", 1'b1, 7'd73, 7'h01, 1'b0, 7'd0, 1'b0);
    step("atk2", 1'b1, 7'd73, 7'h02, 1'b0, 7'd0, 1'b0);
    step("atk3", 1'b1, 7'd73, 7'h03, 1'b0, 7'd0, 1'b0);
    idle("atk_drain", 5, 1'b1);
    check_count("atk_count", 2, 1);

    // Reset-all after nonzero writes, all seven offered in order.
    step("det_write", 1'b1, 7'd94, 7'h11, 1'b0, 7'd0, 1'b1);
    step("sus_write", 1'b1, 7'd79, 7'h05, 1'b0, 7'd0, 1'b1);
    step("reset_all", 1'b1, 7'd121, 7'h2A, 1'b0, 7'd0, 1'b1);
    idle("reset_all_drain", 18, 1'b1);

    // Unmapped CC alongside a program change.
    step("unmapped_pc", 1'b1, 7'd20, 7'h55, 1'b1, 7'h0D, 1'b1);
    idle("pc_pulse", 2, 1'b1);
    step("pc_same", 1'b0, 7'd0, 7'd0, 1'b1, 7'h0D, 1'b1);
    idle("pc_pulse2", 1, 1'b1);

    // Write on the handshake edge of the offered parameter.
    step("rel_write", 1'b1, 7'd72, 7'h09, 1'b0, 7'd0, 1'b0);
    idle("rel_offer", 1, 1'b0);
    step("rel_hs_write", 1'b1, 7'd72, 7'h0A, 1'b0, 7'd0, 1'b1);
    idle("rel_reoffer", 3, 1'b1);

    // Asynchronous reset while a notification is on offer.
    step("dec_write", 1'b1, 7'd75, 7'h44, 1'b1, 7'h03, 1'b0);
    idle("dec_offer", 2, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_reset", 4, 1'b1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      r_cv  = ($urandom_range(0, 9) < 6);
      r_sel = $urandom_range(0, 15);
      if (r_sel < 7)       r_cn = MAP[r_sel];
      else if (r_sel == 7) r_cn = 7'd121;
      else                 r_cn = 7'($urandom_range(0, 127));
      r_val = 7'($urandom_range(0, 127));
      r_pv  = ($urandom_range(0, 7) == 0);
      r_pp  = 7'($urandom_range(0, 127));
      r_rdy = ($urandom_range(0, 2) != 0);
      step("random", r_cv, r_cn, r_val, r_pv, r_pp, r_rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
